// File: rtl/iod_train_pkg.sv
// Shared FSM state encoding and per-tap pass/fail classification for IOD eye training.
package iod_train_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_SETTLE,
    S_SAMPLE,
    S_STEP,
    S_CENTER,
    S_NEXT,
    S_DONE
  } state_t;

  typedef enum logic {
    TAP_FAIL = 1'b0,
    TAP_PASS = 1'b1
  } tap_res_t;

  // An out-of-range delay line can never be a usable sampling point.
  function automatic tap_res_t classify(input logic early, input logic late, input logic oor);
    return (!early && !late && !oor) ? TAP_PASS : TAP_FAIL;
  endfunction

endpackage

// File: rtl/iod_train_window.sv
// Tracks the first and last contiguous passing tap of one lane's sweep and derives the centre tap.
// Updates one cycle after a sample strobe; cleared at the start of every lane.
module iod_train_window
  import iod_train_pkg::*;
#(
  parameter int TAP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             sample,
  input  tap_res_t         res,
  input  logic [TAP_W-1:0] tap,
  output logic [TAP_W-1:0] first,
  output logic [TAP_W-1:0] last,
  output logic             has_pass,
  output logic             ended,
  output logic [TAP_W-1:0] centre
);

  logic [TAP_W:0] sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first    <= '0;
      last     <= '0;
      has_pass <= 1'b0;
    end else if (clr) begin
      first    <= '0;
      last     <= '0;
      has_pass <= 1'b0;
    end else if (sample && res == TAP_PASS && !ended) begin
      if (!has_pass) first <= tap;
      last     <= tap;
      has_pass <= 1'b1;
    end
  end

  // A fail after any pass closes the window; the sweep stops on this sample.
  assign ended  = has_pass && (res == TAP_FAIL);
  assign sum    = {1'b0, first} + {1'b0, last};
  assign centre = TAP_W'(sum >> 1);

endmodule

// File: rtl/iod_eye_train_ctrl.sv
// Sequential per-lane eye training: sweep delay taps up, find the passing window, step back down to its centre.
// Defining IOD_EYE_TRAIN_DEBUG_EN adds WIN_FIRST/WIN_LAST, the recorded window per lane.
module iod_eye_train_ctrl
  import iod_train_pkg::*;
#(
  parameter int NUM_LANES     = 1,
  parameter int TAP_W         = 8,
  parameter int MAX_TAPS      = 128,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic                         FAB_CLK,
  input  logic                         ARST,
  input  logic                         START,
  output logic                         BUSY,
  output logic                         DONE,
  output logic                         FAIL,
  output logic [NUM_LANES-1:0]         LANE_FAIL,
  output logic [NUM_LANES-1:0]         DELAY_LINE_MOVE,
  output logic [NUM_LANES-1:0]         DELAY_LINE_DIRECTION,
  output logic [NUM_LANES-1:0]         DELAY_LINE_LOAD,
  output logic [NUM_LANES-1:0]         EYE_MONITOR_CLEAR_FLAGS,
  input  logic [NUM_LANES-1:0]         EYE_MONITOR_EARLY,
  input  logic [NUM_LANES-1:0]         EYE_MONITOR_LATE,
  input  logic [NUM_LANES-1:0]         DELAY_LINE_OUT_OF_RANGE,
  output logic [NUM_LANES*TAP_W-1:0]   LANE_TAP
`ifdef IOD_EYE_TRAIN_DEBUG_EN
  ,
  output logic [NUM_LANES*TAP_W-1:0]   WIN_FIRST,
  output logic [NUM_LANES*TAP_W-1:0]   WIN_LAST
`endif
);

  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_t               state, nxt;
  logic [LW-1:0]        lane;
  logic [TAP_W-1:0]     tap;
  logic [SW-1:0]        scnt;
  logic                 phase;
  logic                 lane_bad;
  logic [NUM_LANES-1:0] lane_oh;
  tap_res_t             res;
  logic                 oor, stop, last_lane, settle_end, centred;
  logic                 w_has_pass, w_ended;
  logic [TAP_W-1:0]     w_first, w_last, w_centre;

  assign oor        = DELAY_LINE_OUT_OF_RANGE[lane];
  assign res        = classify(EYE_MONITOR_EARLY[lane], EYE_MONITOR_LATE[lane], oor);
  assign stop       = w_ended || oor || (tap == TAP_W'(MAX_TAPS - 1));
  assign last_lane  = (lane == LW'(NUM_LANES - 1));
  assign settle_end = (scnt == SW'(SETTLE_CYCLES - 1));
  assign centred    = (tap == w_centre);

  iod_train_window #(.TAP_W(TAP_W)) u_window (
    .clk      (FAB_CLK),
    .rst      (ARST),
    .clr      (state == S_LOAD),
    .sample   (state == S_SAMPLE),
    .res      (res),
    .tap      (tap),
    .first    (w_first),
    .last     (w_last),
    .has_pass (w_has_pass),
    .ended    (w_ended),
    .centre   (w_centre)
  );

  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) state <= S_IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   if (START) nxt = S_LOAD;
      S_LOAD:   nxt = S_CLEAR;
      S_CLEAR:  nxt = S_SETTLE;
      S_SETTLE: if (settle_end) nxt = S_SAMPLE;
      S_SAMPLE: nxt = stop ? S_CENTER : S_STEP;
      S_STEP:   nxt = S_CLEAR;
      S_CENTER: if (lane_bad || (!phase && centred)) nxt = S_NEXT;
      S_NEXT:   nxt = last_lane ? S_DONE : S_LOAD;
      S_DONE:   nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  always_comb begin
    lane_oh       = '0;
    lane_oh[lane] = 1'b1;
  end

  always_comb begin
    DELAY_LINE_MOVE         = '0;
    DELAY_LINE_DIRECTION    = '0;
    DELAY_LINE_LOAD         = '0;
    EYE_MONITOR_CLEAR_FLAGS = '0;
    BUSY                    = (state != S_IDLE) && (state != S_DONE);
    DONE                    = (state == S_DONE);
    case (state)
      S_LOAD:  DELAY_LINE_LOAD = lane_oh;
      S_CLEAR: EYE_MONITOR_CLEAR_FLAGS = lane_oh;
      S_STEP: begin
        DELAY_LINE_MOVE      = lane_oh;
        DELAY_LINE_DIRECTION = lane_oh;
      end
      // Failed lane gets one reload; otherwise alternate move/idle cycles walking down to centre.
      S_CENTER: begin
        if (lane_bad)               DELAY_LINE_LOAD = lane_oh;
        else if (!phase && !centred) DELAY_LINE_MOVE = lane_oh;
      end
      default: ;
    endcase
  end

  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      lane      <= '0;
      tap       <= '0;
      scnt      <= '0;
      phase     <= 1'b0;
      lane_bad  <= 1'b0;
      LANE_TAP  <= '0;
      LANE_FAIL <= '0;
      FAIL      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (START) begin
          lane      <= '0;
          LANE_TAP  <= '0;
          LANE_FAIL <= '0;
          FAIL      <= 1'b0;
        end
        S_LOAD:   tap  <= '0;
        S_CLEAR:  scnt <= '0;
        S_SETTLE: scnt <= scnt + 1'b1;
        S_SAMPLE: if (stop) begin
          lane_bad <= !(w_has_pass || res == TAP_PASS);
          phase    <= 1'b0;
        end
        S_STEP:   tap <= tap + 1'b1;
        S_CENTER: begin
          if (lane_bad) begin
            tap <= '0;
          end else if (!phase) begin
            if (!centred) begin
              tap   <= tap - 1'b1;
              phase <= 1'b1;
            end
          end else begin
            phase <= 1'b0;
          end
        end
        S_NEXT: begin
          LANE_TAP[int'(lane)*TAP_W +: TAP_W] <= tap;
          LANE_FAIL[lane] <= lane_bad;
          if (lane_bad) FAIL <= 1'b1;
          if (!last_lane) lane <= lane + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef IOD_EYE_TRAIN_DEBUG_EN
  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      WIN_FIRST <= '0;
      WIN_LAST  <= '0;
    end else if (state == S_IDLE && START) begin
      WIN_FIRST <= '0;
      WIN_LAST  <= '0;
    end else if (state == S_NEXT) begin
      WIN_FIRST[int'(lane)*TAP_W +: TAP_W] <= w_first;
      WIN_LAST[int'(lane)*TAP_W +: TAP_W]  <= w_last;
    end
  end
`else
  // Window bounds stay internal to iod_train_window and feed only the centring logic.
`endif

endmodule

// File: doc/iod_eye_train_ctrl.md
IOD_EYE_TRAIN_CTRL -- requirements
Module: iod_eye_train_ctrl

Interface
REQ-001 SHALL have parameter NUM_LANES, default 1: number of IOD lanes trained, 1..16.
REQ-002 SHALL have parameter TAP_W, default 8: delay-line tap index width.
REQ-003 SHALL have parameter MAX_TAPS, default 128: taps swept per lane, 2..2**TAP_W.
REQ-004 SHALL have parameter SETTLE_CYCLES, default 8: wait cycles between flag clear and sample, at least 1.
REQ-005 SHALL have one clock, FAB_CLK (input, 1), with all logic rising-edge on it.
REQ-006 SHALL have reset ARST (input, 1), asynchronous and active-high.
REQ-007 SHALL have ports START (in, 1, training request pulse), BUSY (out, 1) and DONE (out, 1, one-cycle completion pulse).
REQ-008 SHALL have ports FAIL (out, 1, any lane failed; sticky until next accepted START) and LANE_FAIL (out, NUM_LANES).
REQ-009 SHALL have IOD control outputs of width NUM_LANES: DELAY_LINE_MOVE, DELAY_LINE_DIRECTION (1 = increment), DELAY_LINE_LOAD and EYE_MONITOR_CLEAR_FLAGS.
REQ-010 SHALL have IOD status inputs of width NUM_LANES: EYE_MONITOR_EARLY, EYE_MONITOR_LATE and DELAY_LINE_OUT_OF_RANGE.
REQ-011 SHALL have LANE_TAP (out, NUM_LANES*TAP_W): final tap per lane, with lane n at bits [n*TAP_W +: TAP_W].

Function
REQ-012 SHALL accept START only in IDLE; START while BUSY is ignored.
REQ-013 SHALL train lanes sequentially (0 upward) and drive control outputs only for the active lane, holding all others 0.
REQ-014 SHALL step through the FSM states IDLE, LOAD, CLEAR, SETTLE, SAMPLE, STEP, CENTER, NEXT, DONE.
REQ-015 SHALL, in LOAD, pulse DELAY_LINE_LOAD for 1 cycle, then set the tap counter to 0.
REQ-016 SHALL, in CLEAR, pulse EYE_MONITOR_CLEAR_FLAGS for 1 cycle, then hold SETTLE for exactly SETTLE_CYCLES cycles.
REQ-017 SHALL, in SAMPLE, register the flags and treat the tap as pass only if EARLY=0 and LATE=0; EARLY=LATE=1 is a fail.
REQ-018 SHALL record the first pass tap and the last contiguous pass tap per lane.
REQ-019 SHALL end the sweep at the first fail after a pass, when tap = MAX_TAPS-1, or when OUT_OF_RANGE is seen (that tap counts as fail).
REQ-020 SHALL, in STEP, pulse MOVE for 1 cycle with DIRECTION=1, increment the tap, then go back to CLEAR.
REQ-021 SHALL compute centre = (first+last)>>1 using a TAP_W+1-bit sum.
REQ-022 SHALL, in CENTER, issue (current tap − centre) MOVE pulses with DIRECTION=0, each 1 cycle followed by 1 idle cycle; no pulses if the difference is 0.
REQ-023 SHALL, on a lane with no pass tap, set LANE_FAIL[n], pulse LOAD once and set LANE_TAP[n]=0.
REQ-024 SHALL, in DONE, pulse DONE for 1 cycle, clear BUSY the same cycle and return to IDLE.
REQ-025 SHALL leave LANE_TAP/LANE_FAIL stable from DONE until the next accepted START, at which point they clear to 0.

Reset
REQ-026 SHALL, on ARST, immediately force all outputs to 0 and the FSM to IDLE, including mid-sweep; the delay line is not reloaded.
REQ-027 SHALL accept START on the first FAB_CLK edge after ARST deasserts.

Configuration
REQ-028 SHALL support macro IOD_EYE_TRAIN_DEBUG_EN: when defined, adds outputs WIN_FIRST and WIN_LAST (each NUM_LANES*TAP_W), holding the recorded window per lane, reset 0, updated with LANE_TAP; when undefined, these ports and their registers are absent and all other behaviour is identical.

Structure
REQ-029 SHALL put the FSM state enum and the pass/fail encoding in package iod_train_pkg.
REQ-030 SHALL put window tracking (first/last/ended/centre) in sub-module iod_train_window, instanced once and cleared per lane.

Verification
REQ-031 SHALL check: NUM_LANES=2, MAX_TAPS=16, SETTLE_CYCLES=4, lane0 pass taps 4..10 -> sweep ends at tap 11, 4 down MOVEs, LANE_TAP[0]=7, DONE pulse, FAIL=0.
REQ-032 SHALL check: lane1 never passes -> LANE_FAIL=2'b10, FAIL=1, one LOAD pulse on lane1, LANE_TAP[1]=0.
REQ-033 SHALL check: lane0 passes taps 12..15 (to the end) -> last=15, centre 13, 2 down MOVEs.
REQ-034 SHALL check: OUT_OF_RANGE asserted at tap 6 with pass taps 2..5 -> sweep ends at 6, LANE_TAP=3.
REQ-035 SHALL check: ARST asserted mid-SETTLE -> all outputs 0 the same cycle; a new START then retrains from lane 0.
REQ-036 SHALL check: START pulsed while BUSY -> no effect; exactly one DONE is produced.
